// File: rtl/lmdpl_phase_sequencer.sv
// Precharge/evaluate sequencer for one dual-rail LMDPL XOR tile, with codeword checking.
// Optional macro LMDPL_ALARM_LOCK_EN: once the alarm is set, hold IDLE and refuse operands until rst.
module lmdpl_phase_sequencer #(
  parameter int unsigned LATENCY          = 2,
  parameter int unsigned PRECHARGE_CYCLES = 1,
  parameter int unsigned ERR_CNT_W        = 8,
  parameter int unsigned ALARM_THRESH     = 4
) (
  input  logic                 UserCLK,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_a0,
  input  logic                 in_a1,
  input  logic                 in_b0,
  input  logic                 in_b1,
  output logic                 A0_t,
  output logic                 A0_f,
  output logic                 B0_t,
  output logic                 B0_f,
  output logic                 A1_t,
  output logic                 A1_f,
  output logic                 B1_t,
  output logic                 B1_f,
  input  logic                 Z0_t,
  input  logic                 Z0_f,
  input  logic                 Z1_t,
  input  logic                 Z1_f,
  output logic                 out_valid,
  output logic                 out_z0,
  output logic                 out_z1,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 alarm
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, EVAL = 2'd2, DONE = 2'd3} state_e;

  localparam logic [3:0]           PRE_LOAD  = 4'(PRECHARGE_CYCLES - 1);
  localparam logic [3:0]           EVAL_LOAD = 4'(LATENCY);
  localparam logic [ERR_CNT_W-1:0] THRESH    = ERR_CNT_W'(ALARM_THRESH);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX   = {ERR_CNT_W{1'b1}};

  // Single-rail share to {true, false} rail pair.
  function automatic logic [1:0] enc_pair(input logic share);
    enc_pair = {share, ~share};
  endfunction

  // Rail pair to {invalid, value}; 00 and 11 are not legal codewords.
  function automatic logic [1:0] dec_pair(input logic t, input logic f);
    case ({t, f})
      2'b10:   dec_pair = 2'b01;
      2'b01:   dec_pair = 2'b00;
      default: dec_pair = 2'b10;
    endcase
  endfunction

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [3:0]             shares_q, shares_d;   // {a0, a1, b0, b1}
  logic [7:0]             rails_q, rails_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_z0_q, out_z0_d;
  logic                   out_z1_q, out_z1_d;
  logic                   out_err_q, out_err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   alarm_q, alarm_d;
  logic [1:0]             dec0_s, dec1_s;
  logic                   accept_s;
  logic                   lock_s;

  assign accept_s = in_valid & in_ready_q;
  assign dec0_s   = dec_pair(Z0_t, Z0_f);
  assign dec1_s   = dec_pair(Z1_t, Z1_f);

  // State, phase counter and latched operand shares
  always_ff @(posedge UserCLK) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      shares_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shares_q <= shares_d;
    end
  end

  // Next-state: IDLE -> PRE (precharge) -> EVAL (tile latency) -> DONE -> IDLE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shares_d = shares_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d  = PRE;
          cnt_d    = PRE_LOAD;
          shares_d = {in_a0, in_a1, in_b0, in_b1};
        end else begin
          state_d  = IDLE;
        end
      end
      PRE: begin
        if (cnt_q == 4'd0) begin
          state_d = EVAL;
          cnt_d   = EVAL_LOAD;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      EVAL: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values, keyed on the upcoming state so every output is a flop
  always_comb begin
    rails_d     = 8'h00;
    out_valid_d = 1'b0;
    out_z0_d    = out_z0_q;
    out_z1_d    = out_z1_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;
    if (state_d == EVAL) begin
      rails_d = {enc_pair(shares_d[3]), enc_pair(shares_d[1]),
                 enc_pair(shares_d[2]), enc_pair(shares_d[0])};
    end else begin
      rails_d = 8'h00;
    end
    if (state_d == DONE) begin
      out_valid_d = 1'b1;
      out_z0_d    = dec0_s[0];
      out_z1_d    = dec1_s[0];
      out_err_d   = dec0_s[1] | dec1_s[1];
      if (out_err_d && (err_cnt_q != CNT_MAX)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      out_valid_d = 1'b0;
    end
    alarm_d = alarm_q | (err_cnt_d >= THRESH);
`ifdef LMDPL_ALARM_LOCK_EN
    lock_s = alarm_d;
`else
    lock_s = 1'b0;
`endif
    in_ready_d = (state_d == IDLE) & ~lock_s;
  end

  // Output registers
  always_ff @(posedge UserCLK) begin
    if (rst) begin
      rails_q     <= 8'h00;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_z0_q    <= 1'b0;
      out_z1_q    <= 1'b0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= {ERR_CNT_W{1'b0}};
      alarm_q     <= 1'b0;
    end else begin
      rails_q     <= rails_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_z0_q    <= out_z0_d;
      out_z1_q    <= out_z1_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
      alarm_q     <= alarm_d;
    end
  end

  assign {A0_t, A0_f, B0_t, B0_f, A1_t, A1_f, B1_t, B1_f} = rails_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_z0    = out_z0_q;
  assign out_z1    = out_z1_q;
  assign out_err   = out_err_q;
  assign err_count = err_cnt_q;
  assign alarm     = alarm_q;

endmodule

// File: tb/tb_lmdpl_phase_sequencer.sv
// Directed bench: dut0 (LATENCY=0, PRECHARGE_CYCLES=1) and dut1 (LATENCY=2, PRECHARGE_CYCLES=2, ERR_CNT_W=3).
module tb_lmdpl_phase_sequencer;

  logic UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge UserCLK) cyc <= cyc + 1;

  // dut0 signals
  logic       iv0, ir0, ov0, z00, z01, err0, alarm0;
  logic [3:0] sh0, zi0;
  logic [7:0] r0, cnt0;
  // dut1 signals
  logic       iv1, ir1, ov1, z10, z11, err1, alarm1;
  logic [3:0] sh1, zi1;
  logic [7:0] r1;
  logic [2:0] cnt1;
  logic       fault;
  logic [3:0] p1_q, p2_q;

  // Dual-rail XOR tile: {Z0_t, Z0_f, Z1_t, Z1_f}; precharged inputs give 00
  function automatic logic [3:0] tile(input logic [7:0] r);
    tile = {(r[7] & r[4]) | (r[6] & r[5]), (r[7] & r[5]) | (r[6] & r[4]),
            (r[3] & r[0]) | (r[2] & r[1]), (r[3] & r[1]) | (r[2] & r[0])};
  endfunction

  assign zi0 = tile(r0);
  always @(posedge UserCLK) begin
    p1_q <= tile(r1);
    p2_q <= p1_q;
  end
  assign zi1 = fault ? {2'b11, p2_q[1:0]} : p2_q;

  lmdpl_phase_sequencer #(.LATENCY(0), .PRECHARGE_CYCLES(1), .ERR_CNT_W(8), .ALARM_THRESH(4)) dut0 (
    .UserCLK(UserCLK), .rst(rst), .in_valid(iv0), .in_ready(ir0),
    .in_a0(sh0[3]), .in_a1(sh0[2]), .in_b0(sh0[1]), .in_b1(sh0[0]),
    .A0_t(r0[7]), .A0_f(r0[6]), .B0_t(r0[5]), .B0_f(r0[4]),
    .A1_t(r0[3]), .A1_f(r0[2]), .B1_t(r0[1]), .B1_f(r0[0]),
    .Z0_t(zi0[3]), .Z0_f(zi0[2]), .Z1_t(zi0[1]), .Z1_f(zi0[0]),
    .out_valid(ov0), .out_z0(z00), .out_z1(z01), .out_err(err0),
    .err_count(cnt0), .alarm(alarm0));

  lmdpl_phase_sequencer #(.LATENCY(2), .PRECHARGE_CYCLES(2), .ERR_CNT_W(3), .ALARM_THRESH(4)) dut1 (
    .UserCLK(UserCLK), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .in_a0(sh1[3]), .in_a1(sh1[2]), .in_b0(sh1[1]), .in_b1(sh1[0]),
    .A0_t(r1[7]), .A0_f(r1[6]), .B0_t(r1[5]), .B0_f(r1[4]),
    .A1_t(r1[3]), .A1_f(r1[2]), .B1_t(r1[1]), .B1_f(r1[0]),
    .Z0_t(zi1[3]), .Z0_f(zi1[2]), .Z1_t(zi1[1]), .Z1_f(zi1[0]),
    .out_valid(ov1), .out_z0(z10), .out_z1(z11), .out_err(err1),
    .err_count(cnt1), .alarm(alarm1));

  // Bounded: wait for ir1, issue one operand, return on the out_valid cycle
  task automatic run_op1(input logic [3:0] sh, output int acc, output logic ok);
    int n;
    ok  = 1'b0;
    acc = -1;
    n   = 0;
    @(negedge UserCLK);
    while (ir1 !== 1'b1 && n < 40) begin @(negedge UserCLK); n++; end
    if (ir1 === 1'b1) begin
      sh1 = sh; iv1 = 1'b1; acc = cyc;
      @(negedge UserCLK);
      iv1 = 1'b0;
      n = 0;
      while (ov1 !== 1'b1 && n < 40) begin @(negedge UserCLK); n++; end
      ok = (ov1 === 1'b1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; iv0 = 1'b0; iv1 = 1'b0; sh0 = 4'h0; sh1 = 4'h0; fault = 1'b0;
    repeat (3) @(negedge UserCLK);
    checks++; if (ir1 !== 1'b0) begin failures++; $display("FAIL reset_in_ready got %b expected 0", ir1); end
    checks++; if (r1 !== 8'h00) begin failures++; $display("FAIL reset_rails got %h expected 00", r1); end
    checks++; if (ov1 !== 1'b0 || err1 !== 1'b0 || z10 !== 1'b0 || z11 !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got v=%b e=%b z=%b%b expected all 0", ov1, err1, z10, z11); end
    checks++; if (cnt1 !== 3'd0 || alarm1 !== 1'b0) begin
      failures++; $display("FAIL reset_counter got cnt=%0d alarm=%b expected 0/0", cnt1, alarm1); end
    rst = 1'b0;
    @(negedge UserCLK);
    checks++; if (ir1 !== 1'b1 || ir0 !== 1'b1) begin
      failures++; $display("FAIL idle_in_ready got %b%b expected 11", ir0, ir1); end
  endtask

  task automatic test_single();
    int acc;
    int n;
    n = 0;
    while (ir0 !== 1'b1 && n < 20) begin @(negedge UserCLK); n++; end
    sh0 = 4'b1011; iv0 = 1'b1; acc = cyc;
    for (int d = 1; d <= 5; d++) begin
      @(negedge UserCLK);
      iv0 = 1'b0;
      checks++;
      case (d)
        2: if (r0 !== 8'b10100110) begin failures++; $display("FAIL single_eval_rails got %b expected 10100110", r0); end
        default: if (r0 !== 8'h00) begin failures++; $display("FAIL single_precharge_rails d=%0d got %b expected 0", d, r0); end
      endcase
      checks++;
      if (ov0 !== (d == 3)) begin failures++; $display("FAIL single_valid_timing d=%0d got %b", d, ov0); end
      if (d == 3) begin
        checks++;
        if ({z00, z01, err0} !== 3'b010) begin
          failures++; $display("FAIL single_result got z0=%b z1=%b err=%b expected 0 1 0", z00, z01, err0); end
        checks++;
        if (cyc - acc != 3) begin failures++; $display("FAIL single_latency got %0d expected 3", cyc - acc); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [3];
    logic [1:0] expz [3];
    int acc [3];
    int k, r, last;
    logic [7:0] shl;
    ops[0] = 4'b1010; ops[1] = 4'b0110; ops[2] = 4'b0111;
    expz[0] = 2'b00;  expz[1] = 2'b11;  expz[2] = 2'b10;
    k = 0; r = 0; last = 0;
    for (int n = 0; n < 40 && r < 3; n++) begin
      @(negedge UserCLK);
      shl = r1 << 1;
      checks++;
      if ((r1 & shl & 8'hAA) != 8'h00) begin failures++; $display("FAIL rail_pair_11 got %b expected no 11 pair", r1); end
      if (ov1 === 1'b1) begin
        checks++;
        if ({z10, z11} !== expz[r] || err1 !== 1'b0) begin
          failures++; $display("FAIL b2b_result op=%0d got %b%b err=%b expected %b err=0", r, z10, z11, err1, expz[r]); end
        checks++;
        if (cyc - acc[r] != 6) begin failures++; $display("FAIL b2b_latency op=%0d got %0d expected 6", r, cyc - acc[r]); end
        if (r > 0) begin
          checks++;
          if (cyc - last != 7) begin failures++; $display("FAIL b2b_spacing op=%0d got %0d expected 7", r, cyc - last); end
        end
        last = cyc;
        r++;
      end
      if (ir1 === 1'b1) begin
        if (k < 3) begin sh1 = ops[k]; iv1 = 1'b1; acc[k] = cyc; k++; end
        else iv1 = 1'b0;
      end else if (k > 0) begin
        sh1 = ~ops[k-1];
      end
    end
    iv1 = 1'b0;
    checks++;
    if (r != 3) begin failures++; $display("FAIL b2b_timeout got %0d results expected 3", r); end
  endtask

  task automatic test_fault();
    int acc;
    logic ok;
    checks++;
    if (cnt1 !== 3'd0) begin failures++; $display("FAIL fault_precount got %0d expected 0", cnt1); end
    fault = 1'b1;
    run_op1(4'b1001, acc, ok);
    fault = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL fault_timeout got no out_valid expected one"); end
    checks++;
    if ({err1, z10, z11} !== 3'b101) begin
      failures++; $display("FAIL fault_result got err=%b z0=%b z1=%b expected 1 0 1", err1, z10, z11); end
    checks++;
    if (cnt1 !== 3'd1 || alarm1 !== 1'b0) begin
      failures++; $display("FAIL fault_count got cnt=%0d alarm=%b expected 1/0", cnt1, alarm1); end
  endtask

  task automatic test_reset_mid_eval();
    int n;
    logic seen;
    n = 0;
    @(negedge UserCLK);
    while (ir1 !== 1'b1 && n < 20) begin @(negedge UserCLK); n++; end
    sh1 = 4'b1111; iv1 = 1'b1;
    for (int d = 1; d <= 4; d++) begin
      @(negedge UserCLK);
      iv1 = 1'b0;
      if (d == 3) begin
        checks++;
        if (r1 !== 8'b10101010) begin failures++; $display("FAIL abort_eval_rails got %b expected 10101010", r1); end
      end
    end
    rst = 1'b1;
    @(negedge UserCLK);
    checks++;
    if (r1 !== 8'h00 || ov1 !== 1'b0 || ir1 !== 1'b0) begin
      failures++; $display("FAIL abort_state got rails=%h v=%b rdy=%b expected 00 0 0", r1, ov1, ir1); end
    checks++;
    if (cnt1 !== 3'd0) begin failures++; $display("FAIL abort_count got %0d expected 0", cnt1); end
    rst = 1'b0;
    @(negedge UserCLK);
    checks++;
    if (ir1 !== 1'b1) begin failures++; $display("FAIL abort_ready got %b expected 1", ir1); end
    seen = 1'b0;
    repeat (8) begin
      @(negedge UserCLK);
      if (ov1 !== 1'b0 || r1 !== 8'h00) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL abort_no_valid got activity expected none"); end
  endtask

  task automatic test_saturate();
    int acc, nops;
    logic ok;
    logic [2:0] ec;
`ifdef LMDPL_ALARM_LOCK_EN
    logic bad;
    nops = 4;
`else
    nops = 10;
`endif
    fault = 1'b1;
    for (int i = 1; i <= nops; i++) begin
      run_op1(4'b0110, acc, ok);
      ec = (i < 7) ? 3'(i) : 3'd7;
      checks++;
      if (!ok) begin failures++; $display("FAIL sat_timeout op=%0d got no out_valid expected one", i); end
      checks++;
      if (err1 !== 1'b1 || cnt1 !== ec) begin
        failures++; $display("FAIL sat_count op=%0d got err=%b cnt=%0d expected 1 %0d", i, err1, cnt1, ec); end
      checks++;
      if (alarm1 !== (i >= 4)) begin
        failures++; $display("FAIL sat_alarm op=%0d got %b expected %b", i, alarm1, (i >= 4)); end
    end
    fault = 1'b0;
`ifdef LMDPL_ALARM_LOCK_EN
    bad = 1'b0;
    iv1 = 1'b1;
    repeat (20) begin
      @(negedge UserCLK);
      if (ir1 !== 1'b0 || ov1 !== 1'b0 || r1 !== 8'h00) bad = 1'b1;
    end
    iv1 = 1'b0;
    checks++;
    if (bad) begin failures++; $display("FAIL lock_accept got activity expected in_ready held 0"); end
    rst = 1'b1;
    @(negedge UserCLK);
    rst = 1'b0;
    @(negedge UserCLK);
    checks++;
    if (ir1 !== 1'b1 || alarm1 !== 1'b0) begin
      failures++; $display("FAIL lock_release got rdy=%b alarm=%b expected 1 0", ir1, alarm1); end
`else
    run_op1(4'b0110, acc, ok);
    checks++;
    if (!ok || {z10, z11, err1} !== 3'b110) begin
      failures++; $display("FAIL post_alarm_op got ok=%b z=%b%b err=%b expected 1 11 0", ok, z10, z11, err1); end
    checks++;
    if (cnt1 !== 3'd7 || alarm1 !== 1'b1) begin
      failures++; $display("FAIL post_alarm_state got cnt=%0d alarm=%b expected 7 1", cnt1, alarm1); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fault();
    test_reset_mid_eval();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion expected finish");
    $fatal(1);
  end

endmodule
